// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
// Owns HI/LO, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, and holds busy
// for a fixed number of cycles per operation. The result is computed at the
// start edge, held as pending, and committed to HI/LO when the occupancy ends.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   start      EX-stage HI/LO instruction valid this cycle
//   op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b       rs / rt operands (already bypassed)
//   md_use_ID  instruction in ID touches HI/LO
//   hi, lo     HI/LO registers
//   busy       registered, unit occupied
//   stall_md   combinational stall request to the stall unit
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_ID,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1, so clog2(max N) bits suffice.
  localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   hi_next, lo_next;
  logic [31:0]   pend_hi, pend_lo, pend_hi_next, pend_lo_next;
  logic          pend_wr, pend_wr_next;

  logic          is_md;
  logic [63:0]   prod;
  logic [31:0]   a_mag, b_mag, dvd, dvs, uq, ur, quo, rem;
  logic [31:0]   res_hi, res_lo;

  assign is_md = ~op[2];

  // Low 64 bits of the product of the extended operands give both the signed
  // and unsigned results, selected by how the operands are extended.
  always_comb begin
    prod = '0;
    if (op[0]) prod = {32'b0, a} * {32'b0, b};
    else       prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  end

  // One unsigned divider serves both DIV and DIVU: signed division runs on
  // magnitudes and the signs are restored afterwards. The 0x80000000 / -1
  // case falls out naturally (magnitude 2^31, quotient sign positive wraps
  // back to 0x80000000, remainder 0).
  always_comb begin
    a_mag = a[31] ? -a : a;
    b_mag = b[31] ? -b : b;
    dvd   = op[0] ? a : a_mag;
    dvs   = op[0] ? b : b_mag;
    if (dvs == '0) dvs = 32'd1;  // result discarded; avoids an undefined divide
    uq = dvd / dvs;
    ur = dvd % dvs;
    if (op[0]) begin
      quo = uq;
      rem = ur;
    end else begin
      quo = (a[31] ^ b[31]) ? -uq : uq;
      rem = a[31] ? -ur : ur;
    end
  end

  assign res_hi = op[1] ? rem : prod[63:32];
  assign res_lo = op[1] ? quo : prod[31:0];

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    pend_wr_next = pend_wr;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
              pend_wr_next = !(op[1] && (b == '0));
              cnt_next     = op[1] ? DIV_LOAD : MULT_LOAD;
              state_next   = RUN;
            end
            3'b100:  hi_next = a;
            3'b101:  lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == '0) begin
          if (pend_wr) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      pend_wr <= pend_wr_next;
    end
  end

  assign busy     = (state == RUN);
  assign stall_md = md_use_ID & (busy | (start & is_md));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Testbench for md_unit_ctrl: directed test-plan steps followed by random
// traffic, every cycle compared against a behavioural HI/LO model.
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_use_ID;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, stall_md;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_ID(md_use_ID), .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles plus pending result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_wr = 1'b0;
  int          m_rem = 0;

  // Values sampled at the most recent negedge.
  logic [31:0] s_hi, s_lo;
  logic        s_busy, s_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [63:0] pr;
    longint sa, sb, q, r;
    if (reset) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 1'b0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (m_rem == 1 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_rem--;
    end else if (start) begin
      case (op)
        3'd0: begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          pr = 64'(sa * sb);
          p_hi = pr[63:32]; p_lo = pr[31:0]; p_wr = 1'b1; m_rem = MC;
        end
        3'd1: begin
          pr = {32'b0, a} * {32'b0, b};
          p_hi = pr[63:32]; p_lo = pr[31:0]; p_wr = 1'b1; m_rem = MC;
        end
        3'd2: begin
          m_rem = DC;
          p_wr  = (b != 0);
          if (b != 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
        end
        3'd3: begin
          m_rem = DC;
          p_wr  = (b != 0);
          if (b != 0) begin
            p_lo = a / b; p_hi = a % b;
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock: sample and check at negedge, advance model at posedge.
  task automatic cycle();
    logic exp_stall;
    @(negedge clk);
    s_hi = hi; s_lo = lo; s_busy = busy; s_stall = stall_md;
    exp_stall = md_use_ID & ((m_rem > 0) | (start & !op[2]));
    chk("busy",  {31'b0, busy}, {31'b0, m_rem > 0});
    chk("hi",    hi, m_hi);
    chk("lo",    lo, m_lo);
    chk("stall", {31'b0, stall_md}, {31'b0, exp_stall});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic u, input logic r);
    start = s; op = o; a = aa; b = bb; md_use_ID = u; reset = r;
  endtask

  // Issue one op, then idle until busy drops (bounded); counts busy and
  // stall cycles, including the start cycle for stall.
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic u, output int nbusy, output int nstall);
    nbusy = 0; nstall = 0;
    drive(1'b1, o, aa, bb, u, 1'b0);
    cycle();
    if (s_stall) nstall++;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_stall) nstall++;
      if (s_busy) nbusy++;
      else break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int nb, ns;

  initial begin
    drive(1'b0, 3'd7, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    drive(1'b0, 3'd7, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("reset_hi", s_hi, 32'h0);
    chk("reset_lo", s_lo, 32'h0);
    chk("reset_busy", {31'b0, s_busy}, 32'h0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    chk("mult_busy_len", 32'(nb), 32'd5);
    chk("mult_hi", s_hi, 32'hFFFF_FFFF);
    chk("mult_lo", s_lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    chk("multu_hi", s_hi, 32'h0000_0002);
    chk("multu_lo", s_lo, 32'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, nb, ns);
    chk("div_busy_len", 32'(nb), 32'd10);
    chk("div_stall_len", 32'(ns), 32'd11);
    chk("div_stall_fall", {31'b0, s_stall}, 32'h0);
    chk("div_lo", s_lo, 32'hFFFF_FFFD);
    chk("div_hi", s_hi, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd2, 1'b0, nb, ns);
    chk("divu_lo", s_lo, 32'd3);
    chk("divu_hi", s_hi, 32'd1);

    drive(1'b1, 3'd4, 32'h1234_5678, '0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 3'd7, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("mthi_hi", s_hi, 32'h1234_5678);
    chk("mthi_lo", s_lo, 32'd3);
    chk("mthi_busy", {31'b0, s_busy}, 32'h0);

    // MULT issued during a DIV must be ignored.
    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    cycle();
    start = 1'b0;
    nb = 0;
    cycle(); if (s_busy) nb++;
    cycle(); if (s_busy) nb++;
    drive(1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
    cycle(); if (s_busy) nb++;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_busy) nb++;
      else break;
    end
    chk("ign_busy_len", 32'(nb), 32'd10);
    chk("ign_hi", s_hi, 32'd2);
    chk("ign_lo", s_lo, 32'd14);

    drive(1'b1, 3'd4, 32'hAAAA_0000, '0, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'd5, 32'h0000_BBBB, '0, 1'b0, 1'b0); cycle();
    run_op(3'd2, 32'd55, 32'd0, 1'b0, nb, ns);
    chk("div0_busy_len", 32'(nb), 32'd10);
    chk("div0_hi", s_hi, 32'hAAAA_0000);
    chk("div0_lo", s_lo, 32'h0000_BBBB);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
    chk("ovf_lo", s_lo, 32'h8000_0000);
    chk("ovf_hi", s_hi, 32'h0);

    // Reset in the third busy cycle of a MULT.
    drive(1'b1, 3'd0, 32'd5, 32'd6, 1'b0, 1'b0);
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_mid_busy", {31'b0, s_busy}, 32'h0);
    repeat (8) cycle();
    chk("rst_mid_hi", s_hi, 32'h0);
    chk("rst_mid_lo", s_lo, 32'h0);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), pick(), pick(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
